// File: rtl/rx_sync_fsm.sv
// Lane symbol-lock stage after the K28.5 detector: comma-count acquisition, error-count loss of sync,
// and forwarding of in-sync data bytes. Define RX_SYNC_STATS_EN to add the los_events counter.
module rx_sync_fsm #(
  parameter int COMMA_LOCK = 3,
  parameter int ERR_MAX    = 4,
  parameter int GOOD_RUN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [7:0] rx_DataE,
  input  logic       control_dk,
  input  logic       k285,
  input  logic       code_err,
  output logic [7:0] rx_DataS,
  output logic       s_control_dk,
  output logic       rx_valid,
  output logic       sync_ok,
  output logic [2:0] err_cnt
`ifdef RX_SYNC_STATS_EN
  ,
  output logic [15:0] los_events
`endif
);

  localparam int CW = (COMMA_LOCK < 1) ? 1 : $clog2(COMMA_LOCK + 1);
  localparam int GW = (GOOD_RUN < 1) ? 1 : $clog2(GOOD_RUN + 1);

  localparam logic [CW-1:0] LOCK_C    = CW'(COMMA_LOCK);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [GW-1:0] RUN_C     = GW'(GOOD_RUN);
  localparam logic [GW-1:0] G_ONE     = GW'(1);
  localparam logic [2:0]    ERR_MAX_C = 3'(ERR_MAX);

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] comma_cnt;
  logic [GW-1:0] good_cnt;

  // A K28.5 flagged as data is a corrupted comma, so it counts as an error.
  logic sym_bad, sym_comma, sym_good;
  assign sym_bad   = code_err | (k285 & ~control_dk);
  assign sym_comma = ~code_err & k285 & control_dk;
  assign sym_good  = ~sym_bad & ~sym_comma;

`ifdef RX_SYNC_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= LOS;
      comma_cnt    <= '0;
      good_cnt     <= '0;
      err_cnt      <= '0;
      rx_DataS     <= '0;
      s_control_dk <= 1'b0;
      rx_valid     <= 1'b0;
      sync_ok      <= 1'b0;
`ifdef RX_SYNC_STATS_EN
      los_events   <= '0;
`endif
    end else if (!enb) begin
      rx_valid <= 1'b0;
    end else begin
      // Output register: valid only for good symbols seen while already locked.
      rx_DataS     <= rx_DataE;
      s_control_dk <= control_dk;
      rx_valid     <= (state == SYNC) && sym_good;

      case (state)
        LOS: begin
          if (sym_comma) begin
            if (COMMA_LOCK <= 1) begin
              state     <= SYNC;
              sync_ok   <= 1'b1;
              comma_cnt <= '0;
              err_cnt   <= '0;
              good_cnt  <= '0;
            end else begin
              state     <= ACQ;
              comma_cnt <= C_ONE;
            end
          end
        end

        ACQ: begin
          if (sym_bad) begin
            state     <= LOS;
            comma_cnt <= '0;
          end else if (sym_comma) begin
            if (comma_cnt + C_ONE == LOCK_C) begin
              state     <= SYNC;
              sync_ok   <= 1'b1;
              comma_cnt <= '0;
              err_cnt   <= '0;
              good_cnt  <= '0;
            end else begin
              comma_cnt <= comma_cnt + C_ONE;
            end
          end
        end

        SYNC: begin
          if (sym_bad) begin
            if (err_cnt + 3'd1 == ERR_MAX_C) begin
              state     <= LOS;
              sync_ok   <= 1'b0;
              comma_cnt <= '0;
              err_cnt   <= '0;
              good_cnt  <= '0;
`ifdef RX_SYNC_STATS_EN
              los_events <= sat_inc16(los_events);
`endif
            end else begin
              err_cnt  <= err_cnt + 3'd1;
              good_cnt <= '0;
            end
          end else if (err_cnt != 3'd0) begin
            // Each full run of good symbols forgives one earlier error.
            if (good_cnt + G_ONE == RUN_C) begin
              err_cnt  <= err_cnt - 3'd1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + G_ONE;
            end
          end else begin
            good_cnt <= '0;
          end
        end

        default: begin
          state   <= LOS;
          sync_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_sync_fsm.sv
// Scoreboard bench for rx_sync_fsm: directed acquisition/loss scenarios followed by random symbol traffic.
module tb_rx_sync_fsm;

  localparam int COMMA_LOCK = 3;
  localparam int ERR_MAX    = 4;
  localparam int GOOD_RUN   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic [7:0] rx_DataE = 8'h00;
  logic       control_dk = 1'b0;
  logic       k285 = 1'b0;
  logic       code_err = 1'b0;
  logic [7:0] rx_DataS;
  logic       s_control_dk;
  logic       rx_valid;
  logic       sync_ok;
  logic [2:0] err_cnt;
`ifdef RX_SYNC_STATS_EN
  logic [15:0] los_events;
`endif

  rx_sync_fsm #(
    .COMMA_LOCK(COMMA_LOCK),
    .ERR_MAX   (ERR_MAX),
    .GOOD_RUN  (GOOD_RUN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .rx_DataE    (rx_DataE),
    .control_dk  (control_dk),
    .k285        (k285),
    .code_err    (code_err),
    .rx_DataS    (rx_DataS),
    .s_control_dk(s_control_dk),
    .rx_valid    (rx_valid),
    .sync_ok     (sync_ok),
    .err_cnt     (err_cnt)
`ifdef RX_SYNC_STATS_EN
    ,
    .los_events  (los_events)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic        sync;
    logic [2:0]  err;
    logic [7:0]  d;
    logic        c;
    logic [15:0] los;
  } stat_t;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
  } data_t;

  stat_t status_q[$];
  data_t data_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: lock is the count of commas seen since the last error while unlocked.
  bit         m_sync;
  int         m_commas, m_errs, m_goods, m_los;
  logic [7:0] m_d;
  logic       m_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = 1'b0; m_commas = 0; m_errs = 0; m_goods = 0; m_los = 0;
    m_d = 8'h00; m_c = 1'b0;
  endtask

  task automatic sym(input logic e_n, input logic [7:0] d, input logic c, input logic k, input logic er);
    stat_t s;
    data_t dd;
    bit    is_bad, is_comma, vld;
    @(negedge clk);
    enb = e_n; rx_DataE = d; control_dk = c; k285 = k; code_err = er;
    vld = 1'b0;
    if (e_n) begin
      is_bad   = er || (k && !c);
      is_comma = !er && k && c;
      vld      = m_sync && !is_bad && !is_comma;
      m_d = d; m_c = c;
      if (!m_sync) begin
        if (is_comma) begin
          m_commas++;
          if (m_commas >= COMMA_LOCK) begin
            m_sync = 1'b1; m_errs = 0; m_goods = 0; m_commas = 0;
          end
        end else if (is_bad) begin
          m_commas = 0;
        end
      end else if (is_bad) begin
        m_errs++;
        m_goods = 0;
        if (m_errs == ERR_MAX) begin
          m_sync = 1'b0; m_errs = 0; m_commas = 0;
          if (m_los < 65535) m_los++;
        end
      end else if (m_errs > 0) begin
        m_goods++;
        if (m_goods == GOOD_RUN) begin
          m_errs--; m_goods = 0;
        end
      end
    end
    s.vld = vld; s.sync = m_sync; s.err = 3'(m_errs); s.d = m_d; s.c = m_c; s.los = 16'(m_los);
    status_q.push_back(s);
    if (vld) begin
      dd.d = d; dd.c = c;
      data_q.push_back(dd);
    end
  endtask

  task automatic comma();
    sym(1'b1, 8'hBC, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic dat(input logic [7:0] d);
    sym(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bad();
    sym(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
  endtask

  // Monitor: one expected status per enabled-or-idle cycle, plus the payload whenever a byte is valid.
  initial begin
    stat_t e;
    data_t dd;
    forever begin
      @(posedge clk);
      #1;
      if (rst && status_q.size() != 0) begin
        e = status_q.pop_front();
        chk("rx_valid", 32'(rx_valid), 32'(e.vld));
        chk("sync_ok", 32'(sync_ok), 32'(e.sync));
        chk("err_cnt", 32'(err_cnt), 32'(e.err));
        chk("rx_DataS_hold", 32'(rx_DataS), 32'(e.d));
        chk("s_control_dk_hold", 32'(s_control_dk), 32'(e.c));
`ifdef RX_SYNC_STATS_EN
        chk("los_events", 32'(los_events), 32'(e.los));
`endif
        if (rx_valid && e.vld) begin
          dd = data_q.pop_front();
          chk("valid_byte", 32'({rx_DataS, s_control_dk}), 32'({dd.d, dd.c}));
        end
      end
    end
  end

  initial begin
    int r;
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("reset_sync_ok", 32'(sync_ok), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_rx_DataS", 32'(rx_DataS), 32'd0);
    chk("reset_s_control_dk", 32'(s_control_dk), 32'd0);
    @(negedge clk) rst = 1'b1;

    // Acquisition: lock on the third comma, only the following data byte is valid.
    comma(); dat(8'h11); comma(); comma(); dat(8'h22); dat(8'h33);
    // Error decay, then recovery to zero errors.
    bad(); bad(); dat(8'h41); dat(8'h42); dat(8'h43); dat(8'h44);
    dat(8'h45); dat(8'h46); dat(8'h47); dat(8'h48);
    // Loss of sync on the fourth error.
    bad(); bad(); bad(); bad(); dat(8'h55);
    // Acquisition aborted by an error, then restarted.
    comma(); comma(); bad(); comma(); dat(8'h66);
    // code_err wins over a K28.5 during acquisition.
    sym(1'b1, 8'hBC, 1'b1, 1'b1, 1'b1);
    comma(); comma(); comma(); dat(8'h77);
    // Enable low with garbage inputs: nothing moves.
    for (int i = 0; i < 5; i++) sym(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    dat(8'h78);
    // K28.5 marked as data counts as an error in SYNC.
    sym(1'b1, 8'hBC, 1'b0, 1'b1, 1'b0); dat(8'h79);
    dat(8'h7A); dat(8'h7B); dat(8'h7C);

    // Asynchronous reset mid-cycle while locked with two errors.
    bad(); bad(); dat(8'h5A);
    @(posedge clk);
    #3;
    chk("pre_reset_err_cnt", 32'(err_cnt), 32'd2);
    rst = 1'b0;
    #1;
    chk("async_sync_ok", 32'(sync_ok), 32'd0);
    chk("async_rx_valid", 32'(rx_valid), 32'd0);
    chk("async_err_cnt", 32'(err_cnt), 32'd0);
    chk("async_rx_DataS", 32'(rx_DataS), 32'd0);
    enb = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       sym(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else if (r < 42) comma();
      else if (r < 86) sym(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      else if (r < 96) bad();
      else             sym(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    end

    @(negedge clk);
    enb = 1'b0;
    @(negedge clk);
    chk("status_drain", 32'(status_q.size()), 32'd0);
    chk("data_drain", 32'(data_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
